wait_state_memory: RTL and testbench

// - Unified instruction/data memory responder for the multicycle datapath; the slave end of its memory request path.
// - Accepts one read or write request per handshake and completes it after a fixed wait-state latency.
// - Returns a one-cycle done pulse plus read data.
// - Lets the control FSM be stalled on real memory timing instead of a zero-latency combinational array.

---
 rtl/wait_state_memory.sv | 138 +++++++++++++
 tb/tb_wait_state_memory.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wait_state_memory.sv
// Unified instruction/data memory responder with a fixed wait-state latency.
// Latency: request accepted at edge k, done pulse in the cycle after edge k+LATENCY-1.
// Backpressure: busy=1 while an op is in flight; req is dropped (not queued) while busy.
// Optional feature macro: ALIGN_CHECK_EN (misaligned ops flagged with err, writes suppressed).
module wait_state_memory #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2,
   parameter     INIT_FILE   = ""
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic            accept, finish;

   logic            we_q;
   logic [AW-1:0]   idx_q;
   logic [31:0]     wdata_q;

   logic            op_we;
   logic [AW-1:0]   op_idx;
   logic [31:0]     op_wdata;
   logic            op_mis;
   logic            err_q;

   logic [31:0]     mem [DEPTH_WORDS];

   // High address bits alias onto the array; low bits only matter for alignment checking.
   logic unused_addr;
   assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

   // Next-state logic: DONE counts as idle so a held req starts the next op immediately.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      accept   = 1'b0;
      finish   = 1'b0;
      case (state)
         IDLE, DONE: begin
            state_nx = IDLE;
            if (req) begin
               accept = 1'b1;
               if (LATENCY == 1) begin
                  state_nx = DONE;
                  finish   = 1'b1;
               end else begin
                  state_nx = WAIT;
                  cnt_nx   = CW'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            cnt_nx = cnt - CW'(1);
            if (cnt <= CW'(1)) begin
               state_nx = DONE;
               finish   = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register and request latch; reset aborts any op in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            we_q    <= we;
            idx_q   <= addr[AW+1:2];
            wdata_q <= wdata;
         end
      end
   end

   // With LATENCY==1 the op completes on its acceptance edge, so use the live inputs.
   assign op_we    = accept ? we            : we_q;
   assign op_idx   = accept ? addr[AW+1:2]  : idx_q;
   assign op_wdata = accept ? wdata         : wdata_q;

`ifdef ALIGN_CHECK_EN
   logic mis_q;

   // Misalignment is decided at acceptance and carried with the op.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)       mis_q <= 1'b0;
      else if (accept) mis_q <= (addr[1:0] != 2'b00);
   end

   assign op_mis = accept ? (addr[1:0] != 2'b00) : mis_q;
`else
   assign op_mis = 1'b0;
`endif

   // Completion: capture read data and the error flag alongside the done pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdata <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= finish & op_mis;
         if (finish && !op_we)
            rdata <= op_mis ? 32'hDEADBEEF : mem[op_idx];
      end
   end

   // Array write on the edge entering DONE; a misaligned write never lands.
   always_ff @(posedge clock) begin
      if (finish && op_we && !op_mis && !reset)
         mem[op_idx] <= op_wdata;
   end

   assign busy = (state == WAIT);
   assign done = (state == DONE);
   assign err  = err_q;

endmodule

// File: tb/tb_wait_state_memory.sv
// Directed bench for wait_state_memory (DEPTH_WORDS=256, LATENCY=2).
// Inputs are driven 1ns after the rising edge and outputs sampled there too.
// Alignment expectations follow whether ALIGN_CHECK_EN is defined for the build.
module tb_wait_state_memory;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req   = 1'b0;
   logic        we    = 1'b0;
   logic [31:0] addr  = '0;
   logic [31:0] wdata = '0;
   logic        busy, done, err;
   logic [31:0] rdata;

   int errors = 0;
   int checks = 0;

   wait_state_memory #(.DEPTH_WORDS(256), .LATENCY(2), .INIT_FILE("")) dut (
      .clock (clock),
      .reset (reset),
      .req   (req),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .rdata (rdata),
      .err   (err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Issue one op and wait (bounded) for done; returns edges from accept to done.
   task automatic do_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int cyc, output logic found);
      req = 1'b1; we = w; addr = a; wdata = d;
      tick();
      req = 1'b0;
      cyc = 1;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (done) begin
            found = 1'b1;
            break;
         end
         tick();
         cyc++;
      end
   endtask

   int   cyc;
   logic found;

   initial begin
      // Reset from time 0
      #1 reset = 1'b1;
      #1;
      check("rst_busy",  {31'b0, busy}, 32'd0);
      check("rst_done",  {31'b0, done}, 32'd0);
      check("rst_rdata", rdata,         32'd0);
      check("rst_err",   {31'b0, err},  32'd0);
      tick();
      reset = 1'b0;
      tick();

      // Write 0x10 with explicit cycle timing
      req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hCAFEF00D;
      tick();
      req = 1'b0;
      check("wr_busy_c1", {31'b0, busy}, 32'd1);
      check("wr_done_c1", {31'b0, done}, 32'd0);
      tick();
      check("wr_done_c2", {31'b0, done}, 32'd1);
      check("wr_busy_c2", {31'b0, busy}, 32'd0);
      check("wr_err_c2",  {31'b0, err},  32'd0);

      // Read 0x10 back
      do_op(1'b0, 32'h10, 32'h0, cyc, found);
      check("rd_found", {31'b0, found}, 32'd1);
      check("rd_lat",   cyc,            32'd2);
      check("rd_data",  rdata,          32'hCAFEF00D);

      // Async reset mid-cycle while done and rdata are live
      #2 reset = 1'b1;
      #1;
      check("arst_done",  {31'b0, done}, 32'd0);
      check("arst_rdata", rdata,         32'd0);
      check("arst_busy",  {31'b0, busy}, 32'd0);
      check("arst_err",   {31'b0, err},  32'd0);
      tick();
      reset = 1'b0;
      tick();

      // Busy drop: write pulsed during a read is lost
      do_op(1'b1, 32'h24, 32'h22222222, cyc, found);
      check("pre24_found", {31'b0, found}, 32'd1);
      req = 1'b1; we = 1'b0; addr = 32'h20;
      tick();
      check("drop_busy", {31'b0, busy}, 32'd1);
      we = 1'b1; addr = 32'h24; wdata = 32'h11111111;
      tick();
      req = 1'b0;
      check("drop_done", {31'b0, done}, 32'd1);
      tick();
      check("drop_nodone1", {31'b0, done}, 32'd0);
      check("drop_nobusy",  {31'b0, busy}, 32'd0);
      tick();
      check("drop_nodone2", {31'b0, done}, 32'd0);
      do_op(1'b0, 32'h24, 32'h0, cyc, found);
      check("drop_rd24", rdata, 32'h22222222);

      // Back-to-back reads with req held through DONE
      do_op(1'b1, 32'h14, 32'h14141414, cyc, found);
      tick();
      req = 1'b1; we = 1'b0; addr = 32'h10;
      tick();
      check("b2b_c1_done", {31'b0, done}, 32'd0);
      tick();
      check("b2b_c2_done",  {31'b0, done}, 32'd1);
      check("b2b_c2_rdata", rdata,         32'hCAFEF00D);
      addr = 32'h14;
      tick();
      check("b2b_c3_done", {31'b0, done}, 32'd0);
      check("b2b_c3_busy", {31'b0, busy}, 32'd1);
      req = 1'b0;
      tick();
      check("b2b_c4_done",  {31'b0, done}, 32'd1);
      check("b2b_c4_rdata", rdata,         32'h14141414);
      tick();
      check("b2b_c5_done", {31'b0, done}, 32'd0);

      // Address wrap: 0x400 aliases word 0
      do_op(1'b1, 32'h400, 32'h5, cyc, found);
      do_op(1'b0, 32'h0, 32'h0, cyc, found);
      check("wrap_rd0", rdata, 32'h5);

      // Reset aborts a pending write
      do_op(1'b1, 32'h8, 32'hAAAA, cyc, found);
      req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h9;
      tick();
      req = 1'b0;
      check("abort_busy", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("abort_busy_rst", {31'b0, busy}, 32'd0);
      tick();
      check("abort_nodone", {31'b0, done}, 32'd0);
      reset = 1'b0;
      tick();
      do_op(1'b0, 32'h8, 32'h0, cyc, found);
      check("abort_rd8", rdata, 32'hAAAA);

      // Misaligned write to 0x12 (word 4 currently holds 0xCAFEF00D)
      do_op(1'b1, 32'h12, 32'h7, cyc, found);
      check("mis_found", {31'b0, found}, 32'd1);
`ifdef ALIGN_CHECK_EN
      check("mis_wr_err", {31'b0, err}, 32'd1);
      do_op(1'b0, 32'h10, 32'h0, cyc, found);
      check("mis_word4", rdata, 32'hCAFEF00D);
      check("mis_rd_aligned_err", {31'b0, err}, 32'd0);
      do_op(1'b0, 32'h12, 32'h0, cyc, found);
      check("mis_rd_data", rdata, 32'hDEADBEEF);
      check("mis_rd_err", {31'b0, err}, 32'd1);
`else
      check("mis_wr_err", {31'b0, err}, 32'd0);
      do_op(1'b0, 32'h10, 32'h0, cyc, found);
      check("mis_word4", rdata, 32'h7);
      check("mis_rd_err", {31'b0, err}, 32'd0);
`endif
      tick();
      check("final_err", {31'b0, err}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
